// File: rtl/pipe_ctrl.sv
// Valid-bit sequencer for a chain of datapath pipeline registers.
// Ports: clk, rst_n, in_valid/in_ready, out_valid/out_ready, stall, flush, en, clear, occupancy, idle, done_count.
module pipe_ctrl #(
  parameter int STAGES  = 3,
  parameter int COUNT_W = 16,
  parameter int OCC_W   = $clog2(STAGES + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic               stall,
  input  logic               flush,
  output logic [STAGES-1:0]  en,
  output logic [STAGES-1:0]  clear,
  output logic [OCC_W-1:0]   occupancy,
  output logic               idle,
  output logic [COUNT_W-1:0] done_count
);

  logic [STAGES-1:0]  r_vld;
  logic [COUNT_W-1:0] r_cnt;
  logic [STAGES:0]    w_rdy;
  logic               w_run;
  logic               w_hs;
  logic [OCC_W-1:0]   w_occ;

  // A stage can load if it is empty or its successor is moving,
  // so bubbles collapse even under back-pressure.
  always_comb begin
    w_rdy = '0;
    w_rdy[STAGES] = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      w_rdy[i] = !r_vld[i] | w_rdy[i+1];
    end
  end

  always_comb begin
    w_occ = '0;
    for (int i = 0; i < STAGES; i++) begin
      w_occ = w_occ + OCC_W'(r_vld[i]);
    end
  end

  // Reset, stall and flush all freeze movement and mask both handshakes.
  assign w_run      = rst_n & !stall & !flush;
  assign en         = w_run ? w_rdy[STAGES-1:0] : '0;
  assign clear      = (!rst_n | flush) ? '1 : '0;
  assign in_ready   = w_run & w_rdy[0];
  assign out_valid  = w_run & r_vld[STAGES-1];
  assign w_hs       = out_valid & out_ready;
  assign occupancy  = w_occ;
  assign idle       = (r_vld == '0);
  assign done_count = r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
    end else if (flush) begin
      r_vld <= '0;
    end else begin
      if (en[0]) r_vld[0] <= in_valid;
      for (int i = 1; i < STAGES; i++) begin
        if (en[i]) r_vld[i] <= r_vld[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_hs && (r_cnt != {COUNT_W{1'b1}})) begin
      r_cnt <= r_cnt + COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed-vector bench for pipe_ctrl (STAGES=3).
// A second narrow-counter instance shares all inputs to exercise saturation.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready, stall, flush;
  logic        in_ready, out_valid, idle;
  logic [2:0]  en, clear;
  logic [1:0]  occupancy;
  logic [15:0] done_count;
  logic        in_ready2, out_valid2, idle2;
  logic [2:0]  en2, clear2;
  logic [1:0]  occupancy2;
  logic [2:0]  done_count2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.STAGES(3), .COUNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .stall(stall), .flush(flush),
    .en(en), .clear(clear),
    .occupancy(occupancy), .idle(idle),
    .done_count(done_count)
  );

  pipe_ctrl #(.STAGES(3), .COUNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready2),
    .out_valid(out_valid2), .out_ready(out_ready),
    .stall(stall), .flush(flush),
    .en(en2), .clear(clear2),
    .occupancy(occupancy2), .idle(idle2),
    .done_count(done_count2)
  );

  typedef struct {
    logic        iv, ordy, stl, fls;
    logic [2:0]  en, clr;
    logic        ir, ov;
    logic [1:0]  occ;
    logic        idl;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic iv, ordy, stl, fls,
    input logic [2:0] e, c,
    input logic ir, ov,
    input logic [1:0] occ,
    input logic idl,
    input logic [15:0] cnt
  );
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.stl = stl; v.fls = fls;
    v.en = e; v.clr = c; v.ir = ir; v.ov = ov;
    v.occ = occ; v.idl = idl; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step(input vec_t t, input string tag);
    logic [31:0] sat;
    in_valid  = t.iv;
    out_ready = t.ordy;
    stall     = t.stl;
    flush     = t.fls;
    #2;
    sat = (t.cnt > 16'd7) ? 32'd7 : 32'(t.cnt);
    chk({tag, ".en"},   32'(en),         32'(t.en));
    chk({tag, ".clr"},  32'(clear),      32'(t.clr));
    chk({tag, ".ir"},   32'(in_ready),   32'(t.ir));
    chk({tag, ".ov"},   32'(out_valid),  32'(t.ov));
    chk({tag, ".occ"},  32'(occupancy),  32'(t.occ));
    chk({tag, ".idle"}, 32'(idle),       32'(t.idl));
    chk({tag, ".cnt"},  32'(done_count), 32'(t.cnt));
    chk({tag, ".sat"},  32'(done_count2), sat);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // streaming, no back-pressure
    tbl.push_back(mk(1,1,0,0,3'b111,3'b000,1,0,2'd0,1,16'd0));
    tbl.push_back(mk(1,1,0,0,3'b111,3'b000,1,0,2'd1,0,16'd0));
    tbl.push_back(mk(1,1,0,0,3'b111,3'b000,1,0,2'd2,0,16'd0));
    tbl.push_back(mk(1,1,0,0,3'b111,3'b000,1,1,2'd3,0,16'd0));
    tbl.push_back(mk(0,1,0,0,3'b111,3'b000,1,1,2'd3,0,16'd1));
    tbl.push_back(mk(0,1,0,0,3'b111,3'b000,1,1,2'd2,0,16'd2));
    tbl.push_back(mk(0,1,0,0,3'b111,3'b000,1,1,2'd1,0,16'd3));
    tbl.push_back(mk(0,1,0,0,3'b111,3'b000,1,0,2'd0,1,16'd4));
    // fill under back-pressure, then drain while accepting
    tbl.push_back(mk(1,0,0,0,3'b111,3'b000,1,0,2'd0,1,16'd4));
    tbl.push_back(mk(1,0,0,0,3'b111,3'b000,1,0,2'd1,0,16'd4));
    tbl.push_back(mk(1,0,0,0,3'b111,3'b000,1,0,2'd2,0,16'd4));
    tbl.push_back(mk(1,0,0,0,3'b000,3'b000,0,1,2'd3,0,16'd4));
    tbl.push_back(mk(1,1,0,0,3'b111,3'b000,1,1,2'd3,0,16'd4));
    tbl.push_back(mk(0,1,0,0,3'b111,3'b000,1,1,2'd3,0,16'd5));
    tbl.push_back(mk(0,1,0,0,3'b111,3'b000,1,1,2'd2,0,16'd6));
    tbl.push_back(mk(0,1,0,0,3'b111,3'b000,1,1,2'd1,0,16'd7));
    // bubble collapse: A, gap, B with output blocked
    tbl.push_back(mk(1,0,0,0,3'b111,3'b000,1,0,2'd0,1,16'd8));
    tbl.push_back(mk(0,0,0,0,3'b111,3'b000,1,0,2'd1,0,16'd8));
    tbl.push_back(mk(1,0,0,0,3'b111,3'b000,1,0,2'd1,0,16'd8));
    tbl.push_back(mk(0,0,0,0,3'b011,3'b000,1,1,2'd2,0,16'd8));
    tbl.push_back(mk(0,0,0,0,3'b001,3'b000,1,1,2'd2,0,16'd8));
    tbl.push_back(mk(1,1,0,0,3'b111,3'b000,1,1,2'd2,0,16'd8));
    // stall with vld=101
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1,1,1,0,3'b000,3'b000,0,0,2'd2,0,16'd9));
    tbl.push_back(mk(0,1,0,0,3'b111,3'b000,1,1,2'd2,0,16'd9));
    tbl.push_back(mk(0,1,0,0,3'b111,3'b000,1,0,2'd1,0,16'd10));
    tbl.push_back(mk(0,1,0,0,3'b111,3'b000,1,1,2'd1,0,16'd10));
    tbl.push_back(mk(0,0,0,0,3'b111,3'b000,1,0,2'd0,1,16'd11));
    // flush when full
    tbl.push_back(mk(1,0,0,0,3'b111,3'b000,1,0,2'd0,1,16'd11));
    tbl.push_back(mk(1,0,0,0,3'b111,3'b000,1,0,2'd1,0,16'd11));
    tbl.push_back(mk(1,0,0,0,3'b111,3'b000,1,0,2'd2,0,16'd11));
    tbl.push_back(mk(1,1,0,1,3'b000,3'b111,0,0,2'd3,0,16'd11));
    tbl.push_back(mk(0,0,0,0,3'b111,3'b000,1,0,2'd0,1,16'd11));
    // flush wins over stall
    tbl.push_back(mk(1,0,0,0,3'b111,3'b000,1,0,2'd0,1,16'd11));
    tbl.push_back(mk(1,1,1,1,3'b000,3'b111,0,0,2'd1,0,16'd11));
    tbl.push_back(mk(0,0,0,0,3'b111,3'b000,1,0,2'd0,1,16'd11));
    // partial fill before async reset
    tbl.push_back(mk(1,0,0,0,3'b111,3'b000,1,0,2'd0,1,16'd11));
    tbl.push_back(mk(1,0,0,0,3'b111,3'b000,1,0,2'd1,0,16'd11));

    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; stall = 1'b0; flush = 1'b0;
    #2;
    chk("rst.en",   32'(en),         32'd0);
    chk("rst.clr",  32'(clear),      32'h7);
    chk("rst.ir",   32'(in_ready),   32'd0);
    chk("rst.ov",   32'(out_valid),  32'd0);
    chk("rst.occ",  32'(occupancy),  32'd0);
    chk("rst.idle", 32'(idle),       32'd1);
    chk("rst.cnt",  32'(done_count), 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;

    foreach (tbl[i]) step(tbl[i], $sformatf("v%0d", i));

    // async reset between edges with vld=011, done_count=11
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst.clr",  32'(clear),       32'h7);
    chk("arst.en",   32'(en),          32'd0);
    chk("arst.ir",   32'(in_ready),    32'd0);
    chk("arst.ov",   32'(out_valid),   32'd0);
    chk("arst.occ",  32'(occupancy),   32'd0);
    chk("arst.idle", 32'(idle),        32'd1);
    chk("arst.cnt",  32'(done_count),  32'd0);
    chk("arst.sat",  32'(done_count2), 32'd0);
    #2;
    rst_n = 1'b1;
    #1;
    step(mk(1,1,0,0,3'b111,3'b000,1,0,2'd0,1,16'd0), "post0");
    step(mk(0,1,0,0,3'b111,3'b000,1,0,2'd1,0,16'd0), "post1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
